// File: rtl/servo_pkg.sv
// Shared defaults, types and helpers for the multi-channel servo PWM block.
// Optional feature macro used by this slice: SERVO_SLEW_EN (frame-by-frame slew limiting).
package servo_pkg;

  localparam int unsigned CLK_FREQ_DEF  = 100_000_000;
  localparam int unsigned PERIOD_US_DEF = 20_000;
  localparam int unsigned ANGLE_W_DEF   = 8;

  // Microsecond counter width for the default frame length; one spare bit keeps
  // the width arithmetic free of overflow.
  localparam int unsigned US_W = $clog2(PERIOD_US_DEF) + 1;

  typedef logic [ANGLE_W_DEF-1:0] angle_t;

  // Pulse width in microseconds for a given angle code.
  function automatic int unsigned width_of(input int unsigned angle,
                                           input int unsigned min_us,
                                           input int unsigned us_per_lsb);
    return min_us + angle * us_per_lsb;
  endfunction

endpackage

// File: rtl/servo_pwm_ch.sv
// One servo channel: shadow/active angle registers and the width comparator.
// With SERVO_SLEW_EN defined the active angle walks toward the shadow angle by
// at most SLEW_STEP codes per frame; otherwise it copies the shadow directly.
module servo_pwm_ch #(
  parameter int unsigned ANGLE_W       = 8,
  parameter int unsigned ANGLE_MAX     = 200,
  parameter int unsigned MIN_US        = 500,
  parameter int unsigned US_PER_LSB    = 10,
  parameter int unsigned DEFAULT_ANGLE = 100,
`ifdef SERVO_SLEW_EN
  parameter int unsigned SLEW_STEP     = 4,
`endif
  parameter int unsigned CNT_W         = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_wr_en,
  input  logic [ANGLE_W-1:0] i_wr_angle,
  input  logic               i_load,
  input  logic               i_run,
  input  logic [CNT_W-1:0]   i_us_cnt,
  output logic               o_servo
);

  localparam logic [ANGLE_W-1:0] AMAX = ANGLE_W'(ANGLE_MAX);
  localparam logic [ANGLE_W-1:0] ADEF = ANGLE_W'(DEFAULT_ANGLE);
`ifdef SERVO_SLEW_EN
  localparam logic [ANGLE_W-1:0] STEP = ANGLE_W'(SLEW_STEP);
`endif

  logic [ANGLE_W-1:0] shadow_q, shadow_d;
  logic [ANGLE_W-1:0] active_q, active_d;
  logic [CNT_W-1:0]   width_s;
  logic               servo_q, servo_d;

  // Next-state for shadow (clamped write), active (frame load) and the output bit.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    servo_d  = 1'b0;

    if (i_wr_en) begin
      shadow_d = (i_wr_angle > AMAX) ? AMAX : i_wr_angle;
    end else begin
      shadow_d = shadow_q;
    end

    // The load sees the pre-write shadow value, so a write in the load cycle
    // lands one frame later.
    if (i_load) begin
`ifdef SERVO_SLEW_EN
      if (shadow_q > active_q) begin
        active_d = ((shadow_q - active_q) > STEP) ? (active_q + STEP) : shadow_q;
      end else if (shadow_q < active_q) begin
        active_d = ((active_q - shadow_q) > STEP) ? (active_q - STEP) : shadow_q;
      end else begin
        active_d = active_q;
      end
`else
      active_d = shadow_q;
`endif
    end else begin
      active_d = active_q;
    end

    width_s = CNT_W'(MIN_US) + CNT_W'(active_q) * CNT_W'(US_PER_LSB);

    if (i_run) begin
      servo_d = (i_us_cnt < width_s);
    end else begin
      servo_d = 1'b0;
    end
  end

  // Channel state registers with asynchronous reset to the default angle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow_q <= ADEF;
      active_q <= ADEF;
      servo_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      servo_q  <= servo_d;
    end
  end

  assign o_servo = servo_q;

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator with a shared frame period.
// Holds the microsecond prescaler, the frame counter and the write decode;
// per-channel logic lives in servo_pwm_ch. Optional macro: SERVO_SLEW_EN.
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = CLK_FREQ_DEF,
  parameter int unsigned N_CH          = 4,
  parameter int unsigned ANGLE_W       = ANGLE_W_DEF,
  parameter int unsigned ANGLE_MAX     = 200,
  parameter int unsigned MIN_US        = 500,
  parameter int unsigned US_PER_LSB    = 10,
  parameter int unsigned PERIOD_US     = PERIOD_US_DEF,
  parameter int unsigned DEFAULT_ANGLE = 100,
  parameter int unsigned SLEW_STEP     = 4
) (
  input  logic                                       i_clk,
  input  logic                                       i_rst_n,
  input  logic                                       i_wr_en,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] i_wr_ch,
  input  logic [ANGLE_W-1:0]                         i_wr_angle,
  output logic [N_CH-1:0]                            o_servo,
  output logic                                       o_frame_start,
  output logic                                       o_wr_err
);

  localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned PRE_MAX = CLK_FREQ / 1_000_000 - 1;
  localparam int unsigned PRE_W   = (PRE_MAX > 0) ? $clog2(PRE_MAX + 1) : 1;
  localparam int unsigned CNT_W   = $clog2(PERIOD_US) + 1;

  if ((CLK_FREQ % 1_000_000) != 0 || CLK_FREQ == 0 || N_CH < 1 || N_CH > 16 ||
      SLEW_STEP < 1 || width_of(ANGLE_MAX, MIN_US, US_PER_LSB) >= PERIOD_US) begin : g_param_err
    $error("servo_pwm_multi: illegal parameter set");
  end

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] us_cnt_q, us_cnt_d;
  logic             run_q, run_d;
  logic             load_q, load_d;
  logic             err_q, err_d;
  logic             us_tick_s;
  logic             ch_valid_s;

  // Prescaler, frame counter and write-error decode. Until the first tick the
  // counter is held and outputs stay low, so the first tick starts frame 0.
  always_comb begin
    us_tick_s  = (pre_q == PRE_W'(PRE_MAX));
    pre_d      = pre_q;
    us_cnt_d   = us_cnt_q;
    run_d      = run_q;
    load_d     = 1'b0;
    ch_valid_s = (32'(i_wr_ch) < N_CH);

    if (us_tick_s) begin
      pre_d = '0;
      if (!run_q) begin
        run_d    = 1'b1;
        us_cnt_d = '0;
        load_d   = 1'b1;
      end else if (us_cnt_q == CNT_W'(PERIOD_US - 1)) begin
        us_cnt_d = '0;
        load_d   = 1'b1;
      end else begin
        us_cnt_d = us_cnt_q + CNT_W'(1);
      end
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end

    err_d = i_wr_en && !ch_valid_s;
  end

  // Timebase registers; load_q is the frame_load pulse seen as o_frame_start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pre_q    <= '0;
      us_cnt_q <= '0;
      run_q    <= 1'b0;
      load_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      us_cnt_q <= us_cnt_d;
      run_q    <= run_d;
      load_q   <= load_d;
      err_q    <= err_d;
    end
  end

  for (genvar k = 0; k < int'(N_CH); k++) begin : g_ch
    servo_pwm_ch #(
      .ANGLE_W       (ANGLE_W),
      .ANGLE_MAX     (ANGLE_MAX),
      .MIN_US        (MIN_US),
      .US_PER_LSB    (US_PER_LSB),
      .DEFAULT_ANGLE (DEFAULT_ANGLE),
`ifdef SERVO_SLEW_EN
      .SLEW_STEP     (SLEW_STEP),
`endif
      .CNT_W         (CNT_W)
    ) u_ch (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_wr_en    (i_wr_en && ch_valid_s && (i_wr_ch == CH_W'(k))),
      .i_wr_angle (i_wr_angle),
      .i_load     (load_q),
      .i_run      (run_q),
      .i_us_cnt   (us_cnt_q),
      .o_servo    (o_servo[k])
    );
  end

  assign o_frame_start = load_q;
  assign o_wr_err      = err_q;

endmodule
